// File: rtl/bus_arbiter.sv
// Round-robin arbiter sequencing internal requesters onto the single external address/data bus.
// Optional macro BUS_ARB_HOLD_EN adds i_hold so a winner can keep the bus locked across transfers.
module bus_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ-1:0]    i_req_rw,
  input  logic [N_REQ*AW-1:0] i_req_addr,
  input  logic [N_REQ*DW-1:0] i_req_wdata,
`ifdef BUS_ARB_HOLD_EN
  input  logic [N_REQ-1:0]    i_hold,
`endif
  output logic [N_REQ-1:0]    o_gnt,
  output logic [N_REQ-1:0]    o_done,
  output logic                o_err,
  output logic [DW-1:0]       o_rdata,
  output logic [AW-1:0]       o_bus_addr,
  output logic [DW-1:0]       o_bus_wdata,
  output logic                o_bus_rw,
  output logic                o_bus_lock,
  input  logic                i_bus_lock,
  input  logic [DW-1:0]       i_bus_rdata,
  input  logic                i_bus_ack
);

  localparam int unsigned   IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned   CW      = 8;
  localparam logic [IW-1:0] LastIdx = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CntMax  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               err_q, err_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [AW-1:0]      bus_addr_q, bus_addr_d;
  logic [DW-1:0]      bus_wdata_q, bus_wdata_d;
  logic               bus_rw_q, bus_rw_d;
  logic               bus_lock_q, bus_lock_d;
`ifdef BUS_ARB_HOLD_EN
  logic               hold_q, hold_d;
`endif

  logic [AW-1:0]      req_addr  [N_REQ];
  logic [DW-1:0]      req_wdata [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_addr[g]  = i_req_addr[g*AW +: AW];
    assign req_wdata[g] = i_req_wdata[g*DW +: DW];
  end

  // Round-robin scan: first requester at or above rr_q, wrapping to 0.
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] win_idx;
  logic          win_found;

  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    scan_idx  = rr_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && i_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = (scan_idx == LastIdx) ? '0 : scan_idx + IW'(1);
    end
  end

  logic          grant_en;
  logic [IW-1:0] grant_idx;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_rw_d    = bus_rw_q;
    bus_lock_d  = bus_lock_q;
    grant_en    = 1'b0;
    grant_idx   = win_idx;
`ifdef BUS_ARB_HOLD_EN
    hold_d      = hold_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef BUS_ARB_HOLD_EN
        // A held winner keeps the bus; external lock is irrelevant while we own it.
        if (hold_q) begin
          if (i_req[idx_q] && i_hold[idx_q]) begin
            grant_en  = 1'b1;
            grant_idx = idx_q;
          end else begin
            hold_d     = 1'b0;
            bus_lock_d = 1'b0;
          end
        end else
`endif
        if (win_found && !i_bus_lock) begin
          grant_en  = 1'b1;
          grant_idx = win_idx;
        end

        // Request fields are captured straight into the pin registers so they
        // are stable from ADDR until DONE exit.
        if (grant_en) begin
          idx_d            = grant_idx;
          gnt_d            = '0;
          gnt_d[grant_idx] = 1'b1;
          bus_addr_d       = req_addr[grant_idx];
          bus_rw_d         = i_req_rw[grant_idx];
          bus_wdata_d      = i_req_rw[grant_idx] ? req_wdata[grant_idx] : '0;
          bus_lock_d       = 1'b1;
          state_d          = StAddr;
        end
      end

      StAddr: begin
        cnt_d   = '0;
        state_d = StWait;
      end

      StWait: begin
        if (i_bus_ack) begin
          if (!bus_rw_q) begin
            rdata_d = i_bus_rdata;
          end
          done_d  = gnt_q;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          rdata_d = '0;
          done_d  = gnt_q;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      StDone: begin
        rr_d        = (idx_q == LastIdx) ? '0 : idx_q + IW'(1);
        gnt_d       = '0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        bus_rw_d    = 1'b0;
        bus_lock_d  = 1'b0;
        state_d     = StIdle;
`ifdef BUS_ARB_HOLD_EN
        hold_d      = 1'b0;
        if (i_hold[idx_q] && i_req[idx_q]) begin
          hold_d     = 1'b1;
          bus_lock_d = 1'b1;
        end
`endif
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_rw_q    <= 1'b0;
      bus_lock_q  <= 1'b0;
`ifdef BUS_ARB_HOLD_EN
      hold_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_rw_q    <= bus_rw_d;
      bus_lock_q  <= bus_lock_d;
`ifdef BUS_ARB_HOLD_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign o_gnt       = gnt_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_rdata     = rdata_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_bus_rw    = bus_rw_q;
  assign o_bus_lock  = bus_lock_q;

endmodule
